phy_tx_collision_avoid: RTL and testbench
=========================================

PHY_TX_COLLISION_AVOID -- requirements
Module: phy_tx_collision_avoid

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 3'd3: number of re-checks allowed after the first busy-line result.
REQ-002 SHALL have parameter BACKOFF_PERIOD, default 10'd100: number of clk cycles spent in backoff between checks.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port tx_req, input, 1: level; the upper layer requests transmission.
REQ-006 SHALL have port tx_abort, input, 1: level; cancels any in-progress request.
REQ-007 SHALL have port phy_definition_of_idle_done, input, 1: idle check complete, from the idle detector.
REQ-008 SHALL have port phy_definition_of_idle_result, input, 1: 1 = CC idle; valid when done=1.
REQ-009 SHALL have port tx_done, input, 1: pulse from the BMC transmitter; the frame is finished.
REQ-010 SHALL have port phy_definition_of_idle_en, output, 1: registered; enables the idle detector.
REQ-011 SHALL have port tx_start, output, 1: registered 1-cycle pulse; the transmitter may start.
REQ-012 SHALL have port tx_busy, output, 1: registered; high in any state other than S_IDLE.
REQ-013 SHALL have port tx_ok, output, 1: registered 1-cycle pulse; transmission completed.
REQ-014 SHALL have port tx_fail, output, 1: registered 1-cycle pulse; retries exhausted and line never idle.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_CHECK, S_BACKOFF, S_TX, with a 3-bit retry_cnt and a 10-bit backoff_cnt.
REQ-016 SHALL, in S_IDLE with tx_req=1 and tx_abort=0, go to S_CHECK and clear retry_cnt; tx_req in any other state SHALL be ignored.
REQ-017 SHALL drive phy_definition_of_idle_en=1 during every cycle the FSM is in S_CHECK, and 0 otherwise.
REQ-018 SHALL, in S_CHECK with done=1 and result=1, go to S_TX and assert tx_start in the first S_TX cycle only.
REQ-019 SHALL, in S_CHECK with done=1, result=0 and retry_cnt<RETRY_MAX, increment retry_cnt, clear backoff_cnt and go to S_BACKOFF.
REQ-020 SHALL, in S_CHECK with done=1, result=0 and retry_cnt==RETRY_MAX, go to S_IDLE and pulse tx_fail for 1 cycle; the total number of checks is RETRY_MAX+1.
REQ-021 SHALL, in S_BACKOFF, increment backoff_cnt each cycle and go to S_CHECK when backoff_cnt==BACKOFF_PERIOD-1, i.e. after exactly BACKOFF_PERIOD cycles in S_BACKOFF.
REQ-022 SHALL, in S_TX, go to S_IDLE on tx_done=1 (including the tx_start cycle) and pulse tx_ok for 1 cycle.
REQ-023 SHALL ignore done/result outside S_CHECK and ignore tx_done outside S_TX.
REQ-024 SHALL, on tx_abort=1 in any non-idle state, go to S_IDLE next cycle with no tx_ok/tx_fail/tx_start pulse; abort SHALL win over a simultaneous done or tx_done.
REQ-025 SHALL spend at least 1 cycle in S_IDLE after returning there; a tx_req still high is then re-accepted.
REQ-026 SHALL keep tx_ok, tx_fail and tx_start mutually exclusive and never high for 2 consecutive cycles.
REQ-027 SHALL saturate retry_cnt and backoff_cnt; neither counter SHALL wrap.

Reset
REQ-028 SHALL, while rst_n=0, force state=S_IDLE, retry_cnt=0, backoff_cnt=0, and drive all outputs to 0, asynchronously.
REQ-029 SHALL, if reset is asserted mid-check, mid-backoff or mid-TX, abandon the operation, emit no pulse, and accept a new tx_req after release.

Verification
REQ-030 Idle line: tx_req rises at cycle N, paired with a real idle detector and static CC -> en high N+1..N+31, done at N+31, tx_start at N+32 -> tx_done -> tx_ok 1 cycle later.
REQ-031 Busy line: result=0 on every check -> 4 checks separated by 100-cycle backoffs, then a single tx_fail pulse, tx_busy=0, en=0.
REQ-032 Busy, then idle: result=0 on check 1 and result=1 on check 2 -> exactly one backoff, then tx_start; retry_cnt=1 at grant.
REQ-033 Abort priority: tx_abort in the same cycle as done=1,result=1 -> S_IDLE, no tx_start; and tx_abort during S_BACKOFF -> no tx_fail.
REQ-034 Reset mid-S_TX: rst_n low for 2 cycles -> all outputs 0 immediately; after release, tx_req high -> new check begins 1 cycle later.
REQ-035 Back-to-back: tx_req held high across tx_ok -> 1 cycle in S_IDLE, then a new S_CHECK; no overlapping pulses.

Source files
------------

// File: rtl/phy_tx_collision_avoid.sv
// ---------------------------------------------------------------------------
// phy_tx_collision_avoid
//   Collision-avoidance gate in front of the BMC transmitter. A transmit
//   request first runs an idle check on the CC line. If the line is idle, the
//   transmitter is started. If it is busy, the block waits BACKOFF_PERIOD
//   cycles and checks again, up to RETRY_MAX re-checks, then reports failure.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | no request in flight; waiting for tx_req
//   S_CHECK   | idle detector enabled; waiting for done/result
//   S_BACKOFF | line was busy; counting BACKOFF_PERIOD cycles
//   S_TX      | transmitter started; waiting for tx_done
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   tx_req, tx_abort                upper-layer request / cancel (levels)
//   phy_definition_of_idle_done     idle check complete
//   phy_definition_of_idle_result   1 = CC idle (valid with done)
//   tx_done                         transmitter finished the frame (pulse)
//   phy_definition_of_idle_en       idle detector enable (high in S_CHECK)
//   tx_start                        1-cycle pulse on entry to S_TX
//   tx_busy                         high whenever not in S_IDLE
//   tx_ok, tx_fail                  1-cycle completion / give-up pulses
// ---------------------------------------------------------------------------
module phy_tx_collision_avoid #(
  parameter logic [2:0] RETRY_MAX      = 3'd3,
  parameter logic [9:0] BACKOFF_PERIOD = 10'd100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_req,
  input  logic tx_abort,
  input  logic phy_definition_of_idle_done,
  input  logic phy_definition_of_idle_result,
  input  logic tx_done,
  output logic phy_definition_of_idle_en,
  output logic tx_start,
  output logic tx_busy,
  output logic tx_ok,
  output logic tx_fail
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_BACKOFF = 2'd2,
    S_TX      = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] retry_cnt, retry_nxt;
  logic [9:0] backoff_cnt, backoff_nxt;
  logic       ok_nxt, fail_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= S_IDLE;
      retry_cnt                 <= 3'd0;
      backoff_cnt               <= 10'd0;
      phy_definition_of_idle_en <= 1'b0;
      tx_start                  <= 1'b0;
      tx_busy                   <= 1'b0;
      tx_ok                     <= 1'b0;
      tx_fail                   <= 1'b0;
    end else begin
      state                     <= state_nxt;
      retry_cnt                 <= retry_nxt;
      backoff_cnt               <= backoff_nxt;
      // Outputs are registered from the next state so they line up with the
      // cycle the FSM actually occupies that state.
      phy_definition_of_idle_en <= (state_nxt == S_CHECK);
      tx_busy                   <= (state_nxt != S_IDLE);
      tx_start                  <= (state != S_TX) && (state_nxt == S_TX);
      tx_ok                     <= ok_nxt;
      tx_fail                   <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry_cnt;
    backoff_nxt = backoff_cnt;
    ok_nxt      = 1'b0;
    fail_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_req && !tx_abort) begin
          state_nxt = S_CHECK;
          retry_nxt = 3'd0;
        end
      end

      S_CHECK: begin
        if (tx_abort) begin
          state_nxt = S_IDLE;
        end else if (phy_definition_of_idle_done) begin
          if (phy_definition_of_idle_result) begin
            state_nxt = S_TX;
          end else if (retry_cnt < RETRY_MAX) begin
            if (retry_cnt != 3'h7) retry_nxt = retry_cnt + 3'd1;
            backoff_nxt = 10'd0;
            state_nxt   = S_BACKOFF;
          end else begin
            fail_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end

      S_BACKOFF: begin
        if (tx_abort) begin
          state_nxt = S_IDLE;
        end else if (backoff_cnt == BACKOFF_PERIOD - 10'd1) begin
          state_nxt = S_CHECK;
        end else if (backoff_cnt != 10'h3ff) begin
          backoff_nxt = backoff_cnt + 10'd1;
        end
      end

      S_TX: begin
        if (tx_abort) begin
          state_nxt = S_IDLE;
        end else if (tx_done) begin
          ok_nxt    = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_phy_tx_collision_avoid.sv
// ---------------------------------------------------------------------------
// tb_phy_tx_collision_avoid
//   Directed bench for phy_tx_collision_avoid (default parameters: three
//   re-checks, 100-cycle backoff). A vector table covers single-cycle
//   behaviour; hand sequences cover the busy line, busy-then-idle, reset in
//   S_TX and pulse exclusivity. Inputs change 1 ns after the rising edge and
//   outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_phy_tx_collision_avoid;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_req, tx_abort, idle_done, idle_result, tx_done;
  logic idle_en, tx_start, tx_busy, tx_ok, tx_fail;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int n;

  always #5 clk = ~clk;

  phy_tx_collision_avoid dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .tx_req                        (tx_req),
    .tx_abort                      (tx_abort),
    .phy_definition_of_idle_done   (idle_done),
    .phy_definition_of_idle_result (idle_result),
    .tx_done                       (tx_done),
    .phy_definition_of_idle_en     (idle_en),
    .tx_start                      (tx_start),
    .tx_busy                       (tx_busy),
    .tx_ok                         (tx_ok),
    .tx_fail                       (tx_fail)
  );

  // {en, start, busy, ok, fail}
  function automatic logic [4:0] outs();
    return {idle_en, tx_start, tx_busy, tx_ok, tx_fail};
  endfunction

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: en/start/busy/ok/fail got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // inputs: {req, abort, done, result, tx_done}
  task automatic drive(input logic [4:0] v);
    {tx_req, tx_abort, idle_done, idle_result, tx_done} = v;
  endtask

  // Called on the first sample inside S_BACKOFF; counts cycles with en low
  // until the FSM returns to S_CHECK.
  task automatic count_backoff(output int cnt);
    cnt = 1;
    drive(5'b00000);
    while (cnt < 200 && !idle_en) begin
      cyc();
      if (!idle_en) cnt++;
    end
  endtask

  // Pulse exclusivity and single-cycle width monitor.
  logic p_start, p_ok, p_fail;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((32'(tx_start) + 32'(tx_ok) + 32'(tx_fail)) > 1) viol++;
      if ((tx_start && p_start) || (tx_ok && p_ok) || (tx_fail && p_fail)) viol++;
    end
    p_start <= tx_start;
    p_ok    <= tx_ok;
    p_fail  <= tx_fail;
  end

  typedef struct {
    logic [4:0] in;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[24];

  initial begin
    vecs[0]  = '{5'b00000, 5'b00000};  // idle
    vecs[1]  = '{5'b10000, 5'b10100};  // req -> CHECK
    vecs[2]  = '{5'b00110, 5'b01100};  // idle line -> TX, start
    vecs[3]  = '{5'b00001, 5'b00010};  // tx_done in start cycle -> ok
    vecs[4]  = '{5'b00110, 5'b00000};  // done ignored in IDLE
    vecs[5]  = '{5'b00001, 5'b00000};  // tx_done ignored in IDLE
    vecs[6]  = '{5'b10000, 5'b10100};
    vecs[7]  = '{5'b00001, 5'b10100};  // tx_done ignored in CHECK
    vecs[8]  = '{5'b01110, 5'b00000};  // abort beats done/result
    vecs[9]  = '{5'b11000, 5'b00000};  // req with abort not accepted
    vecs[10] = '{5'b10000, 5'b10100};
    vecs[11] = '{5'b00100, 5'b00100};  // busy line -> BACKOFF
    vecs[12] = '{5'b00110, 5'b00100};  // done ignored in BACKOFF
    vecs[13] = '{5'b01000, 5'b00000};  // abort in BACKOFF, no fail
    vecs[14] = '{5'b10000, 5'b10100};
    vecs[15] = '{5'b00110, 5'b01100};
    vecs[16] = '{5'b00000, 5'b00100};  // waiting in TX
    vecs[17] = '{5'b01001, 5'b00000};  // abort beats tx_done, no ok
    vecs[18] = '{5'b10110, 5'b10100};  // done in IDLE does not skip CHECK
    vecs[19] = '{5'b00110, 5'b01100};
    vecs[20] = '{5'b10001, 5'b00010};  // ok, req still held
    vecs[21] = '{5'b10000, 5'b10100};  // re-accepted after 1 IDLE cycle
    vecs[22] = '{5'b01000, 5'b00000};
    vecs[23] = '{5'b00000, 5'b00000};

    rst_n = 1'b0;
    drive(5'b00000);
    cyc();
    cyc();
    chk("reset_outputs", outs(), 5'b00000);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].in);
      cyc();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Busy line on every check: 4 checks, 3 backoffs of 100 cycles, one fail.
    drive(5'b10000);
    cyc();
    chk("busy_enter_check", outs(), 5'b10100);
    for (int k = 0; k < 4; k++) begin
      drive(5'b00000);
      cyc();
      chk($sformatf("busy_check%0d_wait", k), outs(), 5'b10100);
      drive(5'b00100);
      cyc();
      if (k < 3) begin
        chk($sformatf("busy_backoff%0d_enter", k), outs(), 5'b00100);
        count_backoff(n);
        chk_int($sformatf("busy_backoff%0d_len", k), n, 100);
      end else begin
        chk("busy_fail_pulse", outs(), 5'b00001);
        drive(5'b00000);
        cyc();
        chk("busy_after_fail", outs(), 5'b00000);
      end
    end

    // Busy then idle: one backoff, grant with retry_cnt = 1.
    drive(5'b10000);
    cyc();
    drive(5'b00100);
    cyc();
    chk("bti_backoff", outs(), 5'b00100);
    count_backoff(n);
    chk_int("bti_backoff_len", n, 100);
    drive(5'b00110);
    cyc();
    chk("bti_start", outs(), 5'b01100);
    chk_int("bti_retry_cnt", int'(dut.retry_cnt), 1);
    drive(5'b00001);
    cyc();
    chk("bti_ok", outs(), 5'b00010);
    drive(5'b00000);
    cyc();
    chk("bti_idle", outs(), 5'b00000);

    // Reset in the middle of S_TX.
    drive(5'b10000);
    cyc();
    drive(5'b00110);
    cyc();
    drive(5'b00000);
    cyc();
    chk("rst_pre_tx", outs(), 5'b00100);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", outs(), 5'b00000);
    cyc();
    cyc();
    chk("rst_held", outs(), 5'b00000);
    rst_n = 1'b1;
    drive(5'b10000);
    cyc();
    chk("rst_new_check", outs(), 5'b10100);
    drive(5'b01000);
    cyc();
    chk("rst_cleanup", outs(), 5'b00000);

    drive(5'b00000);
    cyc();
    chk_int("pulse_exclusive", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
